// File: rtl/trap_sequencer.sv
// Machine-mode trap / mret sequencer: stalls and flushes the pipeline, issues one CSR write per cycle, then redirects the PC.
// Optional build macro TRAP_MTVAL_EN adds the TVAL state that writes mtval (0x343).
module trap_sequencer (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        illegal_instr_i,
  input  logic        irq_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        stall_o,
  output logic        flush_o,
  output logic        csr_wen_o,
  output logic [11:0] csr_addr_o,
  output logic [31:0] csr_wdata_o,
  output logic        pc_redirect_o,
  output logic [31:0] pc_target_o,
  output logic        busy_o
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_EPC, S_CAUSE, S_TVAL, S_STATUS, S_REDIRECT
  } state_e;

  typedef enum logic [2:0] {
    EV_IRQ, EV_ILLEGAL, EV_EBREAK, EV_ECALL, EV_MRET
  } event_e;

  state_e      state_q, state_d;
  event_e      event_q, event_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:2] mepc_q, mepc_d;
  logic [31:0] pc_target_q, pc_target_d;

  logic        irq_take;
  logic        any_event;
  logic        detect;
  event_e      event_det;
  logic [31:0] cause;
  logic [31:0] status_wdata;
  logic [31:0] target;
  logic [31:0] tvec_base;

`ifdef TRAP_MTVAL_EN
  logic [31:0] instr_q, instr_d;
  logic [31:0] tval;
  logic        unused_inputs;
  assign unused_inputs = ^mepc_i[1:0];
`else
  logic        unused_inputs;
  assign unused_inputs = ^{instr_i, mepc_i[1:0]};
`endif

  // Detection is only meaningful in IDLE; the interrupt outranks every synchronous event.
  assign irq_take  = irq_i & mstatus_i[3];
  assign any_event = irq_take | illegal_instr_i | ebreak_i | ecall_i | mret_i;
  assign detect    = (state_q == S_IDLE) & valid_i & any_event;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    event_det = EV_MRET;
    if (irq_take)             event_det = EV_IRQ;
    else if (illegal_instr_i) event_det = EV_ILLEGAL;
    else if (ebreak_i)        event_det = EV_EBREAK;
    else if (ecall_i)         event_det = EV_ECALL;
  end

  always_comb begin
    event_d   = detect ? event_det : event_q;
    pc_d      = detect ? pc_i      : pc_q;
    mstatus_d = detect ? mstatus_i : mstatus_q;
    mtvec_d   = detect ? mtvec_i   : mtvec_q;
    mepc_d    = detect ? mepc_i[31:2] : mepc_q;
`ifdef TRAP_MTVAL_EN
    instr_d   = detect ? instr_i   : instr_q;
`endif
  end

  always_comb begin
    cause = 32'd11;
    case (event_q)
      EV_IRQ:     cause = 32'h8000_000B;
      EV_ILLEGAL: cause = 32'd2;
      EV_EBREAK:  cause = 32'd3;
      default:    cause = 32'd11;
    endcase
  end

`ifdef TRAP_MTVAL_EN
  always_comb begin
    tval = 32'd0;
    if (event_q == EV_ILLEGAL)     tval = instr_q;
    else if (event_q == EV_EBREAK) tval = pc_q;
  end
`endif

  // Trap entry stacks MIE into MPIE; mret restores it and re-arms MPIE. MPP is always machine mode.
  always_comb begin
    status_wdata = mstatus_q;
    if (event_q == EV_MRET) begin
      status_wdata[3] = mstatus_q[7];
      status_wdata[7] = 1'b1;
    end else begin
      status_wdata[7] = mstatus_q[3];
      status_wdata[3] = 1'b0;
    end
    status_wdata[12:11] = 2'b11;
  end

  // Only mode 2'b01 vectors, and only interrupts; 2'b1x falls back to direct.
  always_comb begin
    tvec_base = {mtvec_q[31:2], 2'b00};
    target    = tvec_base;
    if (event_q == EV_MRET) begin
      target = {mepc_q, 2'b00};
    end else if ((mtvec_q[1:0] == 2'b01) && (event_q == EV_IRQ)) begin
      target = tvec_base + 32'd44;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_target_d   = pc_target_q;
    flush_o       = 1'b0;
    csr_wen_o     = 1'b0;
    csr_addr_o    = 12'h000;
    csr_wdata_o   = 32'd0;
    pc_redirect_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (detect) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        flush_o = 1'b1;
        state_d = (event_q == EV_MRET) ? S_STATUS : S_EPC;
      end
      S_EPC: begin
        csr_wen_o   = 1'b1;
        csr_addr_o  = CSR_MEPC;
        csr_wdata_o = pc_q;
        state_d     = S_CAUSE;
      end
      S_CAUSE: begin
        csr_wen_o   = 1'b1;
        csr_addr_o  = CSR_MCAUSE;
        csr_wdata_o = cause;
`ifdef TRAP_MTVAL_EN
        state_d     = S_TVAL;
`else
        state_d     = S_STATUS;
`endif
      end
`ifdef TRAP_MTVAL_EN
      S_TVAL: begin
        csr_wen_o   = 1'b1;
        csr_addr_o  = CSR_MTVAL;
        csr_wdata_o = tval;
        state_d     = S_STATUS;
      end
`endif
      S_STATUS: begin
        csr_wen_o   = 1'b1;
        csr_addr_o  = CSR_MSTATUS;
        csr_wdata_o = status_wdata;
        pc_target_d = target;
        state_d     = S_REDIRECT;
      end
      S_REDIRECT: begin
        pc_redirect_o = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      // NOTE: the capture registers are reset as well, so no X can reach the CSR write port after reset.
      state_q     <= S_IDLE;
      event_q     <= EV_ECALL;
      pc_q        <= 32'd0;
      mstatus_q   <= 32'd0;
      mtvec_q     <= 32'd0;
      mepc_q      <= 30'd0;
      pc_target_q <= 32'd0;
`ifdef TRAP_MTVAL_EN
      instr_q     <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      event_q     <= event_d;
      pc_q        <= pc_d;
      mstatus_q   <= mstatus_d;
      mtvec_q     <= mtvec_d;
      mepc_q      <= mepc_d;
      pc_target_q <= pc_target_d;
`ifdef TRAP_MTVAL_EN
      instr_q     <= instr_d;
`endif
    end
  end

  // Stall is gated by reset so every output drops to 0 while reset is held.
  assign busy_o      = (state_q != S_IDLE);
  assign stall_o     = reset_i & (busy_o | detect);
  assign pc_target_o = pc_target_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios plus random events against a
// transcript model that lists the expected per-cycle outputs of each sequence.
module tb_trap_sequencer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_i;
  logic [31:0] pc_i, instr_i;
  logic        ecall_i, ebreak_i, mret_i, illegal_instr_i, irq_i;
  logic [31:0] mstatus_i, mtvec_i, mepc_i;
  logic        stall_o, flush_o, csr_wen_o, pc_redirect_o, busy_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_wdata_o, pc_target_o;

  trap_sequencer dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .pc_i(pc_i), .instr_i(instr_i),
    .ecall_i(ecall_i), .ebreak_i(ebreak_i), .mret_i(mret_i), .illegal_instr_i(illegal_instr_i),
    .irq_i(irq_i), .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .stall_o(stall_o), .flush_o(flush_o), .csr_wen_o(csr_wen_o), .csr_addr_o(csr_addr_o),
    .csr_wdata_o(csr_wdata_o), .pc_redirect_o(pc_redirect_o), .pc_target_o(pc_target_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

`ifdef TRAP_MTVAL_EN
  localparam bit MTVAL_EN = 1'b1;
`else
  localparam bit MTVAL_EN = 1'b0;
`endif

  typedef struct packed {
    logic        flush;
    logic        wen;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        redir;
  } cyc_t;

  cyc_t        exp_q[$];
  logic        exp_det;
  logic [31:0] exp_tgt;
  int          checks = 0;
  int          passed = 0;

  // One entry per cycle after T0: the CSR writes in order, bracketed by flush and redirect.
  task automatic model(input logic v, irq, ill, ebr, ecl, mrt,
                       input logic [31:0] pc, instr, ms, tvec, mepc);
    logic [31:0] cause, tval, newms, base;
    bit          is_irq;
    exp_q.delete();
    is_irq  = irq && ms[3];
    exp_det = v && (is_irq || ill || ebr || ecl || mrt);
    if (!exp_det) return;
    base  = tvec & 32'hFFFF_FFFC;
    newms = ms;
    exp_q.push_back('{flush: 1'b1, wen: 1'b0, addr: 12'h0, wdata: 32'h0, redir: 1'b0});
    if (!is_irq && !ill && !ebr && !ecl) begin
      newms[3] = ms[7];
      newms[7] = 1'b1;
      newms[12:11] = 2'b11;
      exp_tgt = mepc & 32'hFFFF_FFFC;
    end else begin
      if (is_irq)   begin cause = 32'h8000_000B; tval = 32'h0;  end
      else if (ill) begin cause = 32'd2;         tval = instr;  end
      else if (ebr) begin cause = 32'd3;         tval = pc;     end
      else          begin cause = 32'd11;        tval = 32'h0;  end
      newms[7] = ms[3];
      newms[3] = 1'b0;
      newms[12:11] = 2'b11;
      exp_tgt = (is_irq && tvec[1:0] == 2'b01) ? base + 32'd44 : base;
      exp_q.push_back('{flush: 1'b0, wen: 1'b1, addr: 12'h341, wdata: pc, redir: 1'b0});
      exp_q.push_back('{flush: 1'b0, wen: 1'b1, addr: 12'h342, wdata: cause, redir: 1'b0});
      if (MTVAL_EN)
        exp_q.push_back('{flush: 1'b0, wen: 1'b1, addr: 12'h343, wdata: tval, redir: 1'b0});
    end
    exp_q.push_back('{flush: 1'b0, wen: 1'b1, addr: 12'h300, wdata: newms, redir: 1'b0});
    exp_q.push_back('{flush: 1'b0, wen: 1'b0, addr: 12'h0, wdata: 32'h0, redir: 1'b1});
  endtask

  task automatic apply(input logic v, irq, ill, ebr, ecl, mrt,
                       input logic [31:0] pc, instr, ms, tvec, mepc);
    valid_i = v; irq_i = irq; illegal_instr_i = ill; ebreak_i = ebr; ecall_i = ecl; mret_i = mrt;
    pc_i = pc; instr_i = instr; mstatus_i = ms; mtvec_i = tvec; mepc_i = mepc;
    model(v, irq, ill, ebr, ecl, mrt, pc, instr, ms, tvec, mepc);
  endtask

  task automatic drive_idle();
    valid_i = 1'b0; irq_i = 1'b0; illegal_instr_i = 1'b0; ebreak_i = 1'b0;
    ecall_i = 1'b0; mret_i = 1'b0;
  endtask

  // Valid-looking events and fresh data while busy: all of it must be ignored.
  task automatic drive_junk();
    valid_i = 1'b1;
    irq_i = 1'($urandom); illegal_instr_i = 1'($urandom); ebreak_i = 1'($urandom);
    ecall_i = 1'($urandom); mret_i = 1'($urandom);
    pc_i = $urandom; instr_i = $urandom; mstatus_i = $urandom; mtvec_i = $urandom; mepc_i = $urandom;
  endtask

  // Called at a negedge right after apply(). With hold set, the event inputs stay as they
  // are (irq dropped after T0) and the check of the idle cycle is left to the caller.
  task automatic run_seq(input string name, input bit hold);
    logic [48:0] obs, expv;
    cyc_t        c;
    int          k;
    #1;
    checks++;
    if (stall_o !== exp_det)
      $display("FAIL %s T0 stall: got %b want %b", name, stall_o, exp_det);
    else passed++;
    @(negedge clk_i);
    if (!exp_det) begin
      checks++;
      if ({busy_o, flush_o, csr_wen_o, pc_redirect_o} !== 4'b0000)
        $display("FAIL %s no-event idle: busy/flush/wen/redir=%b want 0000", name,
                 {busy_o, flush_o, csr_wen_o, pc_redirect_o});
      else passed++;
      drive_idle();
      return;
    end
    if (hold) irq_i = 1'b0;
    k = 1;
    while (exp_q.size() > 0) begin
      c    = exp_q.pop_front();
      obs  = {stall_o, busy_o, flush_o, csr_wen_o, csr_addr_o, csr_wdata_o, pc_redirect_o};
      expv = {2'b11, c};
      checks++;
      if (obs !== expv)
        $display("FAIL %s T%0d outputs: got %h want %h", name, k, obs, expv);
      else passed++;
      if (c.redir) begin
        checks++;
        if (pc_target_o !== exp_tgt)
          $display("FAIL %s T%0d target: got %h want %h", name, k, pc_target_o, exp_tgt);
        else passed++;
      end
      if (!hold) begin
        if (exp_q.size() > 0) drive_junk();
        else drive_idle();
      end
      k++;
      @(negedge clk_i);
    end
    if (!hold) begin
      checks++;
      if ({stall_o, busy_o, pc_target_o} !== {2'b00, exp_tgt})
        $display("FAIL %s T%0d idle/hold: stall=%b busy=%b target=%h want 0 0 %h",
                 name, k, stall_o, busy_o, pc_target_o, exp_tgt);
      else passed++;
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    drive_idle();
    pc_i = '0; instr_i = '0; mstatus_i = '0; mtvec_i = '0; mepc_i = '0;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({stall_o, busy_o, flush_o, csr_wen_o, csr_addr_o, csr_wdata_o, pc_redirect_o, pc_target_o} !== '0)
      $display("FAIL reset outputs: stall=%b busy=%b wen=%b target=%h want all 0",
               stall_o, busy_o, csr_wen_o, pc_target_o);
    else passed++;
    reset_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({stall_o, busy_o, pc_target_o} !== '0)
      $display("FAIL post-reset idle: stall=%b busy=%b target=%h want 0", stall_o, busy_o, pc_target_o);
    else passed++;
  endtask

  task automatic test_ecall();
    apply(1, 0, 0, 0, 1, 0, 32'h100, 32'h73, 32'h8, 32'h200, 32'h0);
    run_seq("ecall", 0);
  endtask

  task automatic test_illegal();
    apply(1, 0, 1, 0, 0, 0, 32'h44, 32'hFFFF_FFFF, 32'h0, 32'h400, 32'h0);
    run_seq("illegal", 0);
    apply(1, 0, 0, 1, 0, 0, 32'h58, 32'h0010_0073, 32'h8, 32'h402, 32'h0);
    run_seq("ebreak", 0);
  endtask

  task automatic test_vectored_irq();
    apply(1, 1, 0, 0, 0, 0, 32'h120, 32'h0, 32'h8, 32'h301, 32'h0);
    run_seq("vectored_irq", 0);
    apply(1, 1, 0, 0, 0, 0, 32'h120, 32'h0, 32'h0, 32'h301, 32'h0);
    run_seq("masked_irq", 0);
    apply(1, 1, 0, 0, 0, 0, 32'h124, 32'h0, 32'h8, 32'h303, 32'h0);
    run_seq("irq_mode3_direct", 0);
  endtask

  task automatic test_mret();
    apply(1, 0, 0, 0, 0, 1, 32'h300, 32'h3020_0073, 32'h1880, 32'h200, 32'h104);
    run_seq("mret", 0);
  endtask

  task automatic test_back_to_back();
    apply(1, 1, 0, 0, 1, 0, 32'h80, 32'h73, 32'h8, 32'h500, 32'h0);
    run_seq("irq_plus_ecall", 1);
    model(valid_i, irq_i, illegal_instr_i, ebreak_i, ecall_i, mret_i,
          pc_i, instr_i, mstatus_i, mtvec_i, mepc_i);
    run_seq("held_ecall", 0);
  endtask

  task automatic test_reset_mid();
    apply(1, 0, 0, 0, 1, 0, 32'h900, 32'h73, 32'h8, 32'h700, 32'h0);
    #1;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({csr_wen_o, csr_addr_o} !== {1'b1, 12'h342})
      $display("FAIL reset_mid in CAUSE: wen=%b addr=%h want 1 342", csr_wen_o, csr_addr_o);
    else passed++;
    #2 reset_i = 1'b0;
    #1;
    checks++;
    if ({stall_o, busy_o, flush_o, csr_wen_o, csr_addr_o, csr_wdata_o, pc_redirect_o, pc_target_o} !== '0)
      $display("FAIL reset_mid outputs: stall=%b busy=%b wen=%b redir=%b target=%h want all 0",
               stall_o, busy_o, csr_wen_o, pc_redirect_o, pc_target_o);
    else passed++;
    @(negedge clk_i);
    drive_idle();
    reset_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({busy_o, pc_redirect_o, pc_target_o} !== '0)
      $display("FAIL reset_mid after release: busy=%b redir=%b target=%h want 0",
               busy_o, pc_redirect_o, pc_target_o);
    else passed++;
    apply(1, 0, 0, 0, 1, 0, 32'h904, 32'h73, 32'h8, 32'h700, 32'h0);
    run_seq("ecall_after_reset", 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      apply($urandom_range(0, 7) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom, $urandom, $urandom, $urandom, $urandom);
      run_seq($sformatf("random_%0d", i), 0);
    end
  endtask

  initial begin
    test_reset();
    test_ecall();
    test_illegal();
    test_vectored_irq();
    test_mret();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $finish;
  end

endmodule
